cheshire_chip_rst_seq: RTL

CHESHIRE_CHIP_RST_SEQ -- requirements
Module: cheshire_chip_rst_seq

---
 rtl/cheshire_chip_pkg.sv | 28 ++
 rtl/cheshire_chip_wdt.sv | 38 +++
 rtl/cheshire_chip_rst_seq.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/cheshire_chip_pkg.sv
// ============================================================================
// Module   : cheshire_chip_pkg
// Brief    : Shared types for the chip reset sequencer and its watchdog.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cheshire_chip_pkg;

    typedef enum logic [1:0] {
        RST_CAUSE_POR = 2'd0,
        RST_CAUSE_SW  = 2'd1,
        RST_CAUSE_WDT = 2'd2
    } rst_cause_e;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } rst_seq_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cheshire_chip_wdt.sv
// ============================================================================
// Module   : cheshire_chip_wdt
// Brief    : Run-phase watchdog; only exists when CHESHIRE_CHIP_RST_WDT_EN is set.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef CHESHIRE_CHIP_RST_WDT_EN
module cheshire_chip_wdt #(
    parameter int unsigned WdtCycles = 2**20
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic run_i,
    input  logic kick_i,
    output logic expire_o
);

    localparam int unsigned              C_CNT_W = $clog2(WdtCycles);
    localparam logic [C_CNT_W-1:0]       C_LAST  = C_CNT_W'(WdtCycles - 1);

    logic [C_CNT_W-1:0] r_cnt;

    // A kick wins over a coincident expiry.
    assign expire_o = run_i && !kick_i && (r_cnt == C_LAST);

    always_ff @(posedge clk_i) begin
        if (!rst_ni || !run_i || kick_i || expire_o) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`endif

`default_nettype wire

// File: rtl/cheshire_chip_rst_seq.sv
// ============================================================================
// Module   : cheshire_chip_rst_seq
// Brief    : Staggered multi-domain reset release with SW warm reset and an
//            optional watchdog (enabled by CHESHIRE_CHIP_RST_WDT_EN).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cheshire_chip_rst_seq
    import cheshire_chip_pkg::*;
#(
    parameter int unsigned NumDomains    = 3,
    parameter int unsigned HoldCycles    = 16,
    parameter int unsigned StaggerCycles = 8,
    parameter int unsigned WdtCycles     = 2**20
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  sw_rst_req_i,
    input  logic                  wdt_kick_i,
    output logic [NumDomains-1:0] domain_rst_no,
    output logic                  all_ready_o,
    output logic                  busy_o,
    output logic [1:0]            rst_cause_o
);

    localparam int unsigned C_CNT_W = $clog2(max_u(HoldCycles, StaggerCycles)) + 1;
    localparam int unsigned C_IDX_W = (NumDomains > 1) ? $clog2(NumDomains) : 1;

    localparam logic [C_CNT_W-1:0]    C_HOLD_LAST  = C_CNT_W'(HoldCycles - 1);
    localparam logic [C_CNT_W-1:0]    C_STAG_LAST  = C_CNT_W'(StaggerCycles - 1);
    localparam logic [NumDomains-1:0] C_DOM_FIRST  = NumDomains'(1);

    if (NumDomains < 1 || NumDomains > 8) begin : g_chk_num_domains
        $error("NumDomains must be within 1..8");
    end
    if (HoldCycles < 1) begin : g_chk_hold
        $error("HoldCycles must be at least 1");
    end
    if (StaggerCycles < 1) begin : g_chk_stagger
        $error("StaggerCycles must be at least 1");
    end
    if (WdtCycles < 2) begin : g_chk_wdt
        $error("WdtCycles must be at least 2");
    end

    rst_seq_state_e          r_state;
    logic [C_CNT_W-1:0]      r_cnt;
    logic [C_IDX_W-1:0]      r_idx;
    logic [NumDomains-1:0]   r_domain_rst_n;
    logic                    r_all_ready;
    logic                    r_busy;
    rst_cause_e              r_cause;

    logic                    w_run;
    logic                    w_wdt_expire;
    logic                    w_warm_rst;

    assign w_run = (r_state == ST_RUN);

`ifdef CHESHIRE_CHIP_RST_WDT_EN
    cheshire_chip_wdt #(
        .WdtCycles (WdtCycles)
    ) i_wdt (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .run_i    (w_run),
        .kick_i   (wdt_kick_i),
        .expire_o (w_wdt_expire)
    );
`else
    logic w_unused_kick;
    assign w_unused_kick = wdt_kick_i;
    assign w_wdt_expire  = 1'b0;
`endif

    assign w_warm_rst = sw_rst_req_i || w_wdt_expire;

    // Domains are released LSB first by shifting ones into a thermometer code.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state        <= ST_HOLD;
            r_cnt          <= '0;
            r_idx          <= '0;
            r_domain_rst_n <= '0;
            r_all_ready    <= 1'b0;
            r_busy         <= 1'b1;
            r_cause        <= RST_CAUSE_POR;
        end else if (w_warm_rst) begin
            r_state        <= ST_HOLD;
            r_cnt          <= '0;
            r_idx          <= '0;
            r_domain_rst_n <= '0;
            r_all_ready    <= 1'b0;
            r_busy         <= 1'b1;
            r_cause        <= w_wdt_expire ? RST_CAUSE_WDT : RST_CAUSE_SW;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (r_cnt == C_HOLD_LAST) begin
                        r_cnt          <= '0;
                        r_idx          <= '0;
                        r_domain_rst_n <= C_DOM_FIRST;
                        if (NumDomains == 1) begin
                            r_state     <= ST_RUN;
                            r_all_ready <= 1'b1;
                            r_busy      <= 1'b0;
                        end else begin
                            r_state     <= ST_RELEASE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (r_cnt == C_STAG_LAST) begin
                        r_cnt          <= '0;
                        r_idx          <= r_idx + 1'b1;
                        r_domain_rst_n <= (r_domain_rst_n << 1) | C_DOM_FIRST;
                        if (32'(r_idx) + 32'd2 == NumDomains) begin
                            r_state     <= ST_RUN;
                            r_all_ready <= 1'b1;
                            r_busy      <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    r_cnt <= '0;
                end
                default: begin
                    r_state        <= ST_HOLD;
                    r_cnt          <= '0;
                    r_idx          <= '0;
                    r_domain_rst_n <= '0;
                    r_all_ready    <= 1'b0;
                    r_busy         <= 1'b1;
                end
            endcase
        end
    end

    assign domain_rst_no = r_domain_rst_n;
    assign all_ready_o   = r_all_ready;
    assign busy_o        = r_busy;
    assign rst_cause_o   = r_cause;

endmodule

`default_nettype wire
